// File: rtl/zap_mode16_halfword_aligner_if.sv
// +--------------------------------------------------------------------------+
// | zap_mode16_halfword_aligner_if: fetch-side and decoder-side bus bundle    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface zap_mode16_halfword_aligner_if;
   logic        i_clear;
   logic        i_stall;
   logic        i_cpsr_ff_t;
   logic        i_fetch_valid;
   logic [31:0] i_fetch_word;
   logic [31:0] i_fetch_pc;
   logic        i_fetch_iabort;
   logic        o_fetch_ready;
   logic [31:0] o_instruction;
   logic        o_instruction_valid;
   logic        o_iabort;
   logic [31:0] o_pc_ff;
   logic [31:0] o_pc_plus_8_ff;
   logic [31:0] o_hw_count;

   modport slave (
      input  i_clear, i_stall, i_cpsr_ff_t, i_fetch_valid, i_fetch_word,
             i_fetch_pc, i_fetch_iabort,
      output o_fetch_ready, o_instruction, o_instruction_valid, o_iabort,
             o_pc_ff, o_pc_plus_8_ff, o_hw_count
   );

   modport master (
      output i_clear, i_stall, i_cpsr_ff_t, i_fetch_valid, i_fetch_word,
             i_fetch_pc, i_fetch_iabort,
      input  o_fetch_ready, o_instruction, o_instruction_valid, o_iabort,
             o_pc_ff, o_pc_plus_8_ff, o_hw_count
   );
endinterface

`default_nettype wire

// File: rtl/zap_mode16_halfword_aligner.sv
// +--------------------------------------------------------------------------+
// | zap_mode16_halfword_aligner: splits fetched words into ARM words or      |
// | Thumb halfwords, one unit per cycle. Option: ZAP_MODE16_ALIGN_STATS_EN.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module zap_mode16_halfword_aligner (
   input  logic                                i_clk,
   input  logic                                i_reset,
   zap_mode16_halfword_aligner_if.slave        bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WORD    = 2'd1;
   localparam logic [1:0] ST_HALF_LO = 2'd2;
   localparam logic [1:0] ST_HALF_HI = 2'd3;

   logic [1:0]  state;
   logic [1:0]  next_state;

   logic [31:0] buf_word;
   logic [31:0] buf_base;
   logic        buf_t;
   logic        buf_abort;

   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic [31:0] pc_plus_q;
   logic        valid_q;
   logic        iabort_q;
   logic [31:0] hw_count;

   logic        fetch_ready;
   logic        accept;
   logic        issue;
   logic [31:0] issue_instr;
   logic [31:0] issue_pc;
   logic [31:0] issue_pc_plus;
   logic        issue_abort;

   // Byte address bit 0 carries no information for either instruction set.
   logic        unused_pc_bit;
   assign unused_pc_bit = bus.i_fetch_pc[0];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         buf_word  <= '0;
         buf_base  <= '0;
         buf_t     <= 1'b0;
         buf_abort <= 1'b0;
         instr_q   <= '0;
         pc_q      <= '0;
         pc_plus_q <= '0;
         valid_q   <= 1'b0;
         iabort_q  <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            buf_word  <= bus.i_fetch_word;
            buf_base  <= {bus.i_fetch_pc[31:2], 2'b00};
            buf_t     <= bus.i_cpsr_ff_t;
            buf_abort <= bus.i_fetch_iabort;
         end
         if (bus.i_clear) begin
            valid_q  <= 1'b0;
            iabort_q <= 1'b0;
         end else if (!bus.i_stall) begin
            valid_q <= issue;
            if (issue) begin
               instr_q   <= issue_instr;
               pc_q      <= issue_pc;
               pc_plus_q <= issue_pc_plus;
               iabort_q  <= issue_abort;
            end
         end
      end
   end

   // The pending unit drains first; a word accepted the same cycle then overwrites the buffer.
   always_comb begin
      next_state = state;
      if (bus.i_clear) begin
         next_state = ST_IDLE;
      end else if (!bus.i_stall) begin
         case (state)
            ST_HALF_LO: next_state = ST_HALF_HI;
            default:    next_state = ST_IDLE;
         endcase
         if (accept) begin
            if (bus.i_fetch_iabort || !bus.i_cpsr_ff_t)
               next_state = ST_WORD;
            else if (bus.i_fetch_pc[1])
               next_state = ST_HALF_HI;
            else
               next_state = ST_HALF_LO;
         end
      end
   end

   always_comb begin
      fetch_ready   = !bus.i_stall && !bus.i_clear && (state != ST_HALF_LO);
      accept        = bus.i_fetch_valid && fetch_ready;
      issue         = !bus.i_stall && !bus.i_clear && (state != ST_IDLE);
      issue_instr   = buf_word;
      issue_pc      = buf_base;
      issue_pc_plus = buf_base + (buf_t ? 32'd4 : 32'd8);
      issue_abort   = buf_abort;
      case (state)
         ST_WORD: begin
            if (buf_abort)
               issue_instr = '0;
         end
         ST_HALF_LO: begin
            issue_instr   = {16'd0, buf_word[15:0]};
            issue_pc_plus = buf_base + 32'd4;
            issue_abort   = 1'b0;
         end
         ST_HALF_HI: begin
            issue_instr   = {16'd0, buf_word[31:16]};
            issue_pc      = buf_base + 32'd2;
            issue_pc_plus = buf_base + 32'd6;
            issue_abort   = 1'b0;
         end
         default: ;
      endcase
   end

`ifdef ZAP_MODE16_ALIGN_STATS_EN
   always_ff @(posedge i_clk) begin
      if (i_reset)
         hw_count <= '0;
      else if (issue && ((state == ST_HALF_LO) || (state == ST_HALF_HI)))
         hw_count <= hw_count + 32'd1;
   end
`else
   assign hw_count = '0;
`endif

   assign bus.o_fetch_ready       = fetch_ready;
   assign bus.o_instruction       = instr_q;
   assign bus.o_instruction_valid = valid_q;
   assign bus.o_iabort            = iabort_q;
   assign bus.o_pc_ff             = pc_q;
   assign bus.o_pc_plus_8_ff      = pc_plus_q;
   assign bus.o_hw_count          = hw_count;

endmodule

`default_nettype wire

// File: tb/tb_zap_mode16_halfword_aligner.sv
// +--------------------------------------------------------------------------+
// | tb_zap_mode16_halfword_aligner: queue-model bench, directed + random.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_zap_mode16_halfword_aligner;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] plus;
      logic        abort;
      logic        half;
   } unit_t;

`ifdef ZAP_MODE16_ALIGN_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic i_clk;
   logic i_reset;
   zap_mode16_halfword_aligner_if bus ();

   zap_mode16_halfword_aligner dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit checking = 1'b0;

   // Model: a queue of units still to be presented, plus the presented unit.
   unit_t       q[$];
   logic        m_valid = 1'b0;
   logic        m_abort = 1'b0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_pc    = '0;
   logic [31:0] m_plus  = '0;
   logic [31:0] m_hw    = '0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] hw_exp(int n);
      return (STATS != 0) ? 32'(n) : 32'd0;
   endfunction

   task automatic model_step();
      unit_t       u;
      logic        rdy;
      logic [31:0] base;
      rdy = !bus.i_stall && !bus.i_clear && (q.size() < 2);
      if (i_reset) begin
         q.delete();
         m_valid = 0; m_abort = 0; m_instr = 0; m_pc = 0; m_plus = 0; m_hw = 0;
      end else if (bus.i_clear) begin
         q.delete();
         m_valid = 0;
         m_abort = 0;
      end else if (!bus.i_stall) begin
         if (q.size() > 0) begin
            u = q.pop_front();
            m_valid = 1; m_instr = u.instr; m_pc = u.pc; m_plus = u.plus; m_abort = u.abort;
            if (u.half) m_hw = m_hw + 1;
         end else begin
            m_valid = 0;
         end
         if (bus.i_fetch_valid && rdy) begin
            base = {bus.i_fetch_pc[31:2], 2'b00};
            if (bus.i_fetch_iabort) begin
               u = '{32'd0, base, base + (bus.i_cpsr_ff_t ? 32'd4 : 32'd8), 1'b1, 1'b0};
               q.push_back(u);
            end else if (!bus.i_cpsr_ff_t) begin
               u = '{bus.i_fetch_word, base, base + 32'd8, 1'b0, 1'b0};
               q.push_back(u);
            end else begin
               if (!bus.i_fetch_pc[1]) begin
                  u = '{{16'd0, bus.i_fetch_word[15:0]}, base, base + 32'd4, 1'b0, 1'b1};
                  q.push_back(u);
               end
               u = '{{16'd0, bus.i_fetch_word[31:16]}, base + 32'd2, base + 32'd6, 1'b0, 1'b1};
               q.push_back(u);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_step();
      #1;
   endtask

   task automatic drive(logic v, logic t, logic [31:0] w, logic [31:0] pc, logic ab);
      bus.i_fetch_valid  = v;
      bus.i_cpsr_ff_t    = t;
      bus.i_fetch_word   = w;
      bus.i_fetch_pc     = pc;
      bus.i_fetch_iabort = ab;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic chk_out(logic [31:0] instr, logic [31:0] pc, logic [31:0] plus);
      chk("lit_valid", 32'(bus.o_instruction_valid), 32'd1);
      chk("lit_instr", bus.o_instruction, instr);
      chk("lit_pc", bus.o_pc_ff, pc);
      chk("lit_pc_plus", bus.o_pc_plus_8_ff, plus);
   endtask

   task automatic chk_ready(logic exp);
      #1;
      chk("lit_ready", 32'(bus.o_fetch_ready), 32'(exp));
   endtask

   always @(negedge i_clk) begin
      if (checking) begin
         chk("ready", 32'(bus.o_fetch_ready),
             32'(!bus.i_stall && !bus.i_clear && (q.size() < 2)));
         chk("valid", 32'(bus.o_instruction_valid), 32'(m_valid));
         chk("iabort", 32'(bus.o_iabort), 32'(m_abort));
         chk("instr", bus.o_instruction, m_instr);
         chk("pc", bus.o_pc_ff, m_pc);
         chk("pc_plus", bus.o_pc_plus_8_ff, m_plus);
         chk("hw_count", bus.o_hw_count, (STATS != 0) ? m_hw : 32'd0);
      end
   end

   initial begin
      i_reset = 1'b1;
      bus.i_clear = 1'b0;
      bus.i_stall = 1'b0;
      idle();
      tick();
      checking = 1'b1;
      tick();
      i_reset = 1'b0;
      chk_ready(1'b1);
      chk("lit_rst_valid", 32'(bus.o_instruction_valid), 32'd0);
      chk("lit_rst_instr", bus.o_instruction, 32'd0);
      chk("lit_rst_pc", bus.o_pc_ff, 32'd0);
      chk("lit_rst_plus", bus.o_pc_plus_8_ff, 32'd0);
      chk("lit_rst_hw", bus.o_hw_count, 32'd0);

      // ARM back-to-back
      drive(1, 0, 32'hE3A00001, 32'h100, 0); chk_ready(1'b1); tick();
      drive(1, 0, 32'hE3A01002, 32'h104, 0); chk_ready(1'b1); tick();
      chk_out(32'hE3A00001, 32'h100, 32'h108);
      idle(); tick();
      chk_out(32'hE3A01002, 32'h104, 32'h10C);
      tick();
      chk("lit_arm_idle", 32'(bus.o_instruction_valid), 32'd0);

      // Thumb aligned, next word waits one cycle then issues without a bubble
      drive(1, 1, 32'h46C02001, 32'h200, 0); tick();
      drive(1, 1, 32'h11112222, 32'h204, 0); chk_ready(1'b0); tick();
      chk_out(32'h00002001, 32'h200, 32'h204);
      chk_ready(1'b1); tick();
      chk_out(32'h000046C0, 32'h202, 32'h206);
      idle(); tick();
      chk_out(32'h00002222, 32'h204, 32'h208);
      tick();
      chk_out(32'h00001111, 32'h206, 32'h20A);
      tick();
      chk("lit_t_idle", 32'(bus.o_instruction_valid), 32'd0);
      chk("lit_hw4", bus.o_hw_count, hw_exp(4));

      // Thumb unaligned target: low half skipped
      drive(1, 1, 32'h1234ABCD, 32'h302, 0); tick();
      idle(); tick();
      chk_out(32'h00001234, 32'h302, 32'h306);
      tick();
      chk("lit_unal_idle", 32'(bus.o_instruction_valid), 32'd0);

      // Stall with high half pending
      drive(1, 1, 32'h46C02001, 32'h200, 0); tick();
      idle(); tick();
      chk_out(32'h00002001, 32'h200, 32'h204);
      bus.i_stall = 1'b1;
      repeat (3) begin
         chk_ready(1'b0);
         tick();
         chk_out(32'h00002001, 32'h200, 32'h204);
      end
      bus.i_stall = 1'b0;
      tick();
      chk_out(32'h000046C0, 32'h202, 32'h206);
      tick();
      chk("lit_stall_idle", 32'(bus.o_instruction_valid), 32'd0);
      chk("lit_hw7", bus.o_hw_count, hw_exp(7));

      // Abort in Thumb mode: single unit, zero instruction, no count
      drive(1, 1, 32'hFFFFFFFF, 32'h400, 1); tick();
      idle(); tick();
      chk("lit_ab_valid", 32'(bus.o_instruction_valid), 32'd1);
      chk("lit_ab_iabort", 32'(bus.o_iabort), 32'd1);
      chk("lit_ab_instr", bus.o_instruction, 32'd0);
      chk("lit_ab_pc", bus.o_pc_ff, 32'h400);
      tick();
      chk("lit_ab_once", 32'(bus.o_instruction_valid), 32'd0);
      chk("lit_ab_hw", bus.o_hw_count, hw_exp(7));

      // Clear together with stall while high half pending
      drive(1, 1, 32'h46C02001, 32'h200, 0); tick();
      idle(); tick();
      chk_out(32'h00002001, 32'h200, 32'h204);
      bus.i_clear = 1'b1;
      bus.i_stall = 1'b1;
      chk_ready(1'b0);
      tick();
      bus.i_clear = 1'b0;
      bus.i_stall = 1'b0;
      chk("lit_clr_valid", 32'(bus.o_instruction_valid), 32'd0);
      chk("lit_clr_iabort", 32'(bus.o_iabort), 32'd0);
      chk_ready(1'b1);
      chk("lit_clr_hw", bus.o_hw_count, hw_exp(8));
      tick();
      chk("lit_clr_drop", 32'(bus.o_instruction_valid), 32'd0);

      // Randomized traffic against the queue model
      for (int i = 0; i < 4000; i++) begin
         i_reset     = ($urandom_range(0, 199) == 0);
         bus.i_clear = ($urandom_range(0, 19) == 0);
         bus.i_stall = ($urandom_range(0, 6) == 0);
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom,
               ($urandom_range(0, 15) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom,
               $urandom_range(0, 9) == 0);
         tick();
      end
      i_reset = 1'b0;
      bus.i_clear = 1'b0;
      bus.i_stall = 1'b0;
      idle();
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
